// File: rtl/word_serializer_pkg.sv
// Shared definitions for the parallel-word serial link.
// The serializer and the matching deserializer both import this package.
package dffx;

  localparam int dff_bits_count = 8;

  localparam bit SER_PARITY_EVEN = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

endpackage

// File: rtl/word_serializer.sv
// Transmit side of the parallel-word path: takes one word per handshake and
// emits it one bit per beat with first/last markers and an optional parity beat.
module word_serializer
  import dffx::*;
#(
  parameter int BITS_COUNT = dff_bits_count,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS_COUNT-1:0] in_data,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  ser_bit,
  output logic                  ser_first,
  output logic                  ser_last
);

  localparam int CNT_W = $clog2(BITS_COUNT + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(BITS_COUNT - 1);

  if (BITS_COUNT < 2) begin : g_bad_width
    $error("word_serializer: BITS_COUNT must be at least 2");
  end

  ser_state_t            state_q, state_d;
  logic [BITS_COUNT-1:0] shift_q, shift_d, shift_next;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  parity_q, parity_d;
  logic                  data_bit;
  logic                  last_data;
  logic                  fire;
  logic                  accept;

  // The outgoing bit always sits at one end of the shift register.
  if (MSB_FIRST) begin : g_msb_first
    assign data_bit   = shift_q[BITS_COUNT-1];
    assign shift_next = {shift_q[BITS_COUNT-2:0], 1'b0};
  end else begin : g_lsb_first
    assign data_bit   = shift_q[0];
    assign shift_next = {1'b0, shift_q[BITS_COUNT-1:1]};
  end

  assign last_data = (state_q == SHIFT) && (cnt_q == LAST_DATA);
  assign ser_valid = (state_q != IDLE);
  assign ser_bit   = (state_q == PARITY) ? parity_q : data_bit;
  assign ser_first = (state_q == SHIFT) && (cnt_q == '0);
  assign ser_last  = (state_q == PARITY) || (!PARITY_EN && last_data);
  assign fire      = ser_valid && ser_ready;

  // Combinational ser_ready -> in_ready path lets the next word load on the
  // final-beat edge so frames run back to back without an idle cycle.
  assign in_ready = reset_n && ((state_q == IDLE) || (fire && ser_last));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        if (fire) begin
          shift_d = shift_next;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_data) begin
            cnt_d   = '0;
            state_d = PARITY_EN ? PARITY : IDLE;
          end
        end
      end
      PARITY: begin
        if (fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d  = SHIFT;
      shift_d  = in_data;
      cnt_d    = '0;
      parity_d = (^in_data) ^ !SER_PARITY_EVEN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: two instances (MSB-first with parity,
// LSB-first without) share stimulus and are each checked against a beat-list model.
module tb_word_serializer;

  localparam int W = 8;

  typedef struct {
    logic [7:0] word;
    logic [8:0] expA;
    logic [7:0] expB;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         inValid = 1'b0;
  logic [W-1:0] inData = '0;
  logic         serReady = 1'b0;

  logic inReadyA, serValidA, serBitA, serFirstA, serLastA;
  logic inReadyB, serValidB, serBitB, serFirstB, serLastB;

  int checks = 0;
  int failures = 0;

  logic [2:0] expQ[2][$];
  logic       logQ[2][$];
  logic [2:0] prevBeat[2];
  logic       prevStall[2];
  int         accepts[2];

  vec_t vecs[5];

  always #5 clk = ~clk;

  word_serializer #(.BITS_COUNT(W), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dutA (
    .clk(clk), .reset_n(reset_n), .in_valid(inValid), .in_ready(inReadyA),
    .in_data(inData), .ser_valid(serValidA), .ser_ready(serReady),
    .ser_bit(serBitA), .ser_first(serFirstA), .ser_last(serLastA)
  );

  word_serializer #(.BITS_COUNT(W), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dutB (
    .clk(clk), .reset_n(reset_n), .in_valid(inValid), .in_ready(inReadyB),
    .in_data(inData), .ser_valid(serValidB), .ser_ready(serReady),
    .ser_bit(serBitB), .ser_first(serFirstB), .ser_last(serLastB)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: instance 0 sends MSB first plus an even-parity beat, instance 1 LSB first only.
  task automatic pushFrame(input int d, input logic [W-1:0] w);
    int  len;
    int  idx;
    bit  par;
    par = (d == 0);
    len = W + (par ? 1 : 0);
    for (int i = 0; i < W; i++) begin
      idx = (d == 0) ? (W - 1 - i) : i;
      expQ[d].push_back({w[idx], i == 0, i == len - 1});
    end
    if (par) expQ[d].push_back({($countones(w) % 2) == 1, 1'b0, 1'b1});
  endtask

  task automatic scoreDut(input int d, input logic v, input logic b, input logic f,
                          input logic l, input logic inRdy);
    string tag;
    logic [2:0] e;
    tag = (d == 0) ? "A" : "B";
    if (reset_n) begin
      if (prevStall[d]) begin
        checkOutput({tag, " hold valid"}, 32'(v), 32'd1);
        checkOutput({tag, " hold beat"}, 32'({b, f, l}), 32'(prevBeat[d]));
      end
      if (v && serReady) begin
        if (expQ[d].size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL %s unexpected beat: got %0h expected none", tag, {b, f, l});
        end else begin
          e = expQ[d].pop_front();
          checkOutput({tag, " beat"}, 32'({b, f, l}), 32'(e));
        end
        logQ[d].push_back(b);
      end
      checkOutput({tag, " in_ready"}, 32'(inRdy), 32'((!v) || (serReady && l)));
      if (inValid && inRdy) begin
        pushFrame(d, inData);
        accepts[d]++;
      end
    end
    prevStall[d] = reset_n && v && !serReady;
    prevBeat[d]  = {b, f, l};
  endtask

  task automatic step();
    #1;
    scoreDut(0, serValidA, serBitA, serFirstA, serLastA, inReadyA);
    scoreDut(1, serValidB, serBitB, serFirstB, serLastB, inReadyB);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] data, input logic rdy);
    inValid  = v;
    inData   = data;
    serReady = rdy;
  endtask

  task automatic clearLogs();
    logQ[0].delete();
    logQ[1].delete();
  endtask

  function automatic logic [31:0] logBits(input int d);
    logic [31:0] v;
    v = '0;
    foreach (logQ[d][i]) v = (v << 1) | 32'(logQ[d][i]);
    return v;
  endfunction

  task automatic waitIdle(input int budget, input string name);
    int n;
    n = 0;
    while ((serValidA || serValidB) && n < budget) begin
      step();
      n++;
    end
    checkOutput({name, " drained"}, 32'(serValidA || serValidB), 32'd0);
  endtask

  task automatic sendWord(input logic [W-1:0] w, input string name);
    clearLogs();
    applyStimulus(1'b1, w, 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    waitIdle(40, name);
  endtask

  task automatic enterReset();
    reset_n = 1'b0;
    expQ[0].delete();
    expQ[1].delete();
    prevStall[0] = 1'b0;
    prevStall[1] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int validCnt;
    int firstIdx;
    int lastIdx;
    int cyc;
    int startAcc;
    bit pat[4];

    vecs[0] = '{8'hA5, 9'b101001010, 8'b10100101};
    vecs[1] = '{8'h01, 9'b000000011, 8'b10000000};
    vecs[2] = '{8'hF0, 9'b111100000, 8'b00001111};
    vecs[3] = '{8'h3C, 9'b001111000, 8'b00111100};
    vecs[4] = '{8'h80, 9'b100000001, 8'b00000001};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    accepts[0] = 0;
    accepts[1] = 0;

    // Reset state, including in_ready held low while reset is asserted.
    enterReset();
    applyStimulus(1'b1, 8'h55, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("reset in_ready A", 32'(inReadyA), 32'd0);
    checkOutput("reset in_ready B", 32'(inReadyB), 32'd0);
    checkOutput("reset ser_valid A", 32'(serValidA), 32'd0);
    checkOutput("reset markers A", 32'({serBitA, serFirstA, serLastA}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset: ready and silent for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
      #1;
      checkOutput("idle in_ready A", 32'(inReadyA), 32'd1);
      checkOutput("idle ser_valid A", 32'(serValidA || serValidB), 32'd0);
      step();
    end

    $display("[TB] table-driven single frames");
    foreach (vecs[i]) begin
      sendWord(vecs[i].word, "table");
      checkOutput("table A length", 32'(logQ[0].size()), 32'd9);
      checkOutput("table A bits", logBits(0), 32'(vecs[i].expA));
      checkOutput("table B length", 32'(logQ[1].size()), 32'd8);
      checkOutput("table B bits", logBits(1), 32'(vecs[i].expB));
    end

    $display("[TB] back-to-back frames");
    clearLogs();
    startAcc = accepts[0];
    validCnt = 0;
    firstIdx = -1;
    lastIdx = -1;
    cyc = 0;
    applyStimulus(1'b1, 8'h01, 1'b1);
    while (cyc < 60 && !(cyc > 4 && !serValidA && !serValidB)) begin
      if (serValidA) begin
        validCnt++;
        if (firstIdx < 0) firstIdx = cyc;
        lastIdx = cyc;
      end
      step();
      cyc++;
      if (accepts[0] == startAcc + 1) inData = 8'h80;
      if (accepts[0] >= startAcc + 2) inValid = 1'b0;
    end
    checkOutput("b2b valid cycles", 32'(validCnt), 32'd18);
    checkOutput("b2b contiguous span", 32'(lastIdx - firstIdx + 1), 32'd18);
    checkOutput("b2b A bits", logBits(0), 32'b000000011100000001);
    waitIdle(40, "b2b");

    $display("[TB] backpressure pattern");
    clearLogs();
    applyStimulus(1'b1, 8'hF0, pat[0]);
    step();
    inValid = 1'b0;
    cyc = 1;
    while ((serValidA || serValidB) && cyc < 100) begin
      serReady = pat[cyc % 4];
      step();
      cyc++;
    end
    checkOutput("bp drained", 32'(serValidA || serValidB), 32'd0);
    checkOutput("bp A length", 32'(logQ[0].size()), 32'd9);
    checkOutput("bp A bits", logBits(0), 32'b111100000);
    checkOutput("bp B bits", logBits(1), 32'b00001111);

    $display("[TB] reset mid-frame");
    clearLogs();
    applyStimulus(1'b1, 8'hFF, 1'b1);
    step();
    inValid = 1'b0;
    cyc = 0;
    while (logQ[0].size() < 3 && cyc < 20) begin
      step();
      cyc++;
    end
    checkOutput("midreset beats before", 32'(logQ[0].size()), 32'd3);
    enterReset();
    #1;
    checkOutput("midreset ser_valid A", 32'(serValidA), 32'd0);
    checkOutput("midreset ser_valid B", 32'(serValidB), 32'd0);
    checkOutput("midreset markers A", 32'({serBitA, serFirstA, serLastA}), 32'd0);
    checkOutput("midreset in_ready A", 32'(inReadyA), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("post reset in_ready A", 32'(inReadyA), 32'd1);
    checkOutput("post reset ser_valid A", 32'(serValidA), 32'd0);
    @(negedge clk);
    sendWord(8'h3C, "post reset");
    checkOutput("post reset A length", 32'(logQ[0].size()), 32'd9);
    checkOutput("post reset A bits", logBits(0), 32'b001111000);
    checkOutput("post reset B bits", logBits(1), 32'b00111100);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 7);
      step();
    end
    applyStimulus(1'b0, '0, 1'b1);
    waitIdle(60, "random");
    checkOutput("random A queue empty", 32'(expQ[0].size()), 32'd0);
    checkOutput("random B queue empty", 32'(expQ[1].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
